// File: rtl/mul_int_seq.sv
// rtl/mul_int_seq.sv - iterative shift-add integer multiplier with valid/ready handshakes
//
// Purpose:
//   Multiplies two WIDTH-bit operands, signed or unsigned per operation,
//   into an exact 2*WIDTH-bit product. BITS_PER_CYCLE multiplier bits are
//   retired per clock, so one operation takes N = WIDTH/BITS_PER_CYCLE
//   cycles in BUSY. Only one operation is in flight at a time.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands presented
//   in_ready   block idle and able to accept an operation
//   A, B       multiplicand / multiplier (WIDTH bits)
//   is_signed  1 = two's-complement operands, 0 = unsigned
//   out_valid  product available
//   out_ready  consumer accepts the product
//   P_lo/P_hi  low / high WIDTH bits of the product, held until the next result
module mul_int_seq #(
   parameter int WIDTH          = 16,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             is_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] P_lo,
   output logic [WIDTH-1:0] P_hi
);

   localparam int N     = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam int PW    = 2 * WIDTH;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [PW-1:0]      acc_q, acc_d;
   logic [PW-1:0]      mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               neg_q, neg_d;
   logic [PW-1:0]      p_q, p_d;

   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [PW-1:0]      partial;
   logic [PW-1:0]      acc_sum;

   // Magnitudes of the operands. For the most-negative value the negation
   // wraps back to 100..0, which is exactly its magnitude read as unsigned.
   assign a_mag = (is_signed && A[WIDTH-1]) ? -A : A;
   assign b_mag = (is_signed && B[WIDTH-1]) ? -B : B;

   // Partial product for this iteration: the already-shifted multiplicand
   // times the lowest BITS_PER_CYCLE bits of the right-shifting multiplier.
   always_comb begin
      partial = '0;
      for (int j = 0; j < BITS_PER_CYCLE; j++) begin
         if (mplier_q[j]) begin
            partial = partial + (mcand_q << j);
         end
      end
   end

   assign acc_sum = acc_q + partial;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      p_d      = p_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               mcand_d  = {{WIDTH{1'b0}}, a_mag};
               mplier_d = b_mag;
               neg_d    = is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
               cnt_d    = '0;
               acc_d    = '0;
               state_d  = S_BUSY;
            end
         end
         S_BUSY: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << BITS_PER_CYCLE;
            mplier_d = mplier_q >> BITS_PER_CYCLE;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N - 1)) begin
               // Sign is applied on the last iteration edge so the product
               // is already final in the cycle out_valid rises.
               p_d     = neg_q ? -acc_sum : acc_sum;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         p_q      <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         p_q      <= p_d;
      end
   end

   // Handshake outputs decode registered state only.
   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign P_lo      = p_q[WIDTH-1:0];
   assign P_hi      = p_q[PW-1:WIDTH];

endmodule

// File: tb/tb_mul_int_seq.sv
// tb/tb_mul_int_seq.sv - directed self-checking bench for mul_int_seq
module tb_mul_int_seq;

   logic clk = 1'b0;
   logic rst;

   // dut0: WIDTH=16, BITS_PER_CYCLE=1
   logic        iv0, ir0, sg0, ov0, or0;
   logic [15:0] a0, b0, lo0, hi0;
   // dut1: WIDTH=16, BITS_PER_CYCLE=4
   logic        iv1, ir1, sg1, ov1, or1;
   logic [15:0] a1, b1, lo1, hi1;

   int err_cnt = 0;
   int chk_cnt = 0;

   always #5 clk = ~clk;

   mul_int_seq #(.WIDTH(16), .BITS_PER_CYCLE(1)) dut0 (
      .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0),
      .is_signed(sg0), .out_valid(ov0), .out_ready(or0), .P_lo(lo0), .P_hi(hi0)
   );

   mul_int_seq #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
      .is_signed(sg1), .out_valid(ov1), .out_ready(or1), .P_lo(lo1), .P_hi(hi1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic s);
      if (sel) begin iv1 = v; a1 = a; b1 = b; sg1 = s; end
      else     begin iv0 = v; a0 = a; b0 = b; sg0 = s; end
   endtask

   task automatic set_ordy(input bit sel, input logic r);
      if (sel) or1 = r; else or0 = r;
   endtask

   // Full operation: accept, count latency, check product, optionally hold
   // out_ready low for `hold` cycles, then complete the output handshake.
   task automatic run_op(input bit sel, input logic [15:0] a, input logic [15:0] b, input bit sgn,
                         input logic [15:0] exp_hi, input logic [15:0] exp_lo, input int hold,
                         input string tag);
      int lat;
      int exp_lat;
      exp_lat = sel ? 4 : 16;
      check({tag, " in_ready idle"}, sel ? ir1 : ir0, 1);
      drive(sel, 1'b1, a, b, sgn);
      @(posedge clk); #1;
      // Scramble inputs while busy; they must be ignored.
      drive(sel, 1'b1, ~a, 16'h5A5A, ~sgn);
      check({tag, " in_ready busy"}, sel ? ir1 : ir0, 0);
      lat = 0;
      while (!(sel ? ov1 : ov0) && lat < 64) begin
         @(posedge clk); #1;
         lat++;
      end
      drive(sel, 1'b0, 16'h0, 16'h0, 1'b0);
      check({tag, " latency"}, lat, exp_lat);
      check({tag, " P_hi"}, sel ? hi1 : hi0, exp_hi);
      check({tag, " P_lo"}, sel ? lo1 : lo0, exp_lo);
      for (int k = 0; k < hold; k++) begin
         @(posedge clk); #1;
         check({tag, " hold out_valid"}, sel ? ov1 : ov0, 1);
         check({tag, " hold P"}, sel ? {hi1, lo1} : {hi0, lo0}, {exp_hi, exp_lo});
         check({tag, " hold in_ready"}, sel ? ir1 : ir0, 0);
      end
      set_ordy(sel, 1'b1);
      @(posedge clk); #1;
      set_ordy(sel, 1'b0);
      check({tag, " post out_valid"}, sel ? ov1 : ov0, 0);
      check({tag, " post in_ready"}, sel ? ir1 : ir0, 1);
      check({tag, " post P kept"}, sel ? {hi1, lo1} : {hi0, lo0}, {exp_hi, exp_lo});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      iv0 = 0; a0 = 0; b0 = 0; sg0 = 0; or0 = 0;
      iv1 = 0; a1 = 0; b1 = 0; sg1 = 0; or1 = 0;
      #2;
      check("reset in_ready", ir0, 1);
      check("reset out_valid", ov0, 0);
      check("reset P", {hi0, lo0}, 32'h0);
      check("reset4 in_ready", ir1, 1);
      check("reset4 out_valid", ov1, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(0, 16'h0003, 16'h0005, 0, 16'h0000, 16'h000F, 0, "u 3x5");
      run_op(0, 16'hFFFF, 16'hFFFF, 0, 16'hFFFE, 16'h0001, 0, "u ffff^2");
      run_op(0, 16'hFFFF, 16'hFFFF, 1, 16'h0000, 16'h0001, 0, "s -1x-1");
      run_op(0, 16'h8000, 16'h8000, 1, 16'h4000, 16'h0000, 0, "s min^2");
      run_op(0, 16'hFFFD, 16'h0005, 1, 16'hFFFF, 16'hFFF1, 0, "s -3x5");
      run_op(0, 16'h0000, 16'h1234, 0, 16'h0000, 16'h0000, 0, "u zero");
      // 0x1234 * 0x10 = 0x12340, held in DONE for 10 cycles
      run_op(0, 16'h1234, 16'h0010, 0, 16'h0001, 16'h2340, 10, "bp hold");
      // back-to-back: 32767 * -32768 = -0x3FFF8000 = 0xC0008000
      run_op(0, 16'h7FFF, 16'h8000, 1, 16'hC000, 16'h8000, 0, "b2b");

      // Reset during BUSY iteration 7
      check("rst-mid idle", ir0, 1);
      drive(0, 1'b1, 16'h1234, 16'h5678, 1'b0);
      @(posedge clk); #1;
      drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      check("rst-mid pre busy", ir0, 0);
      rst = 1'b1;
      #1;
      check("rst-mid out_valid", ov0, 0);
      check("rst-mid in_ready", ir0, 1);
      check("rst-mid P", {hi0, lo0}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_op(0, 16'h0007, 16'h0009, 0, 16'h0000, 16'h003F, 0, "after rst 7x9");

      // BITS_PER_CYCLE=4: 4660 * -292 = -1360720 = 0xFFEB3CB0
      run_op(1, 16'h1234, 16'hFEDC, 1, 16'hFFEB, 16'h3CB0, 0, "bpc4 signed");
      run_op(1, 16'hFFFF, 16'hFFFF, 0, 16'hFFFE, 16'h0001, 0, "bpc4 u ffff^2");
      run_op(1, 16'h8000, 16'h8000, 1, 16'h4000, 16'h0000, 2, "bpc4 min^2");

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
